bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Round-robin arbiter sharing the single downstream memory/bus interface between the AES FSM and the SHA FSM.
- Both FSMs are fed by the request queue and issue multi-beat read/write transactions; this block grants one requester at a time.
- A granted requester holds the bus until its last beat is accepted, it aborts, or a watchdog expires.
- Sits between the two FSMs and the bus serializer.

Parameters:
- ADDRW, 24, address width of each beat.
- DATAW, 8, data width of each beat.
- TIMEOUT, 255, maximum consecutive granted cycles without an accepted beat before forced release (must be >= 1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_aes  in  1  AES FSM requests or holds the bus; beat valid while granted
- addr_aes  in  ADDRW  AES beat address
- data_aes  in  DATAW  AES beat write data
- wr_aes  in  1  AES beat is a write (1) or a read (0)
- last_aes  in  1  current AES beat is the final beat of the transaction
- req_sha, addr_sha, data_sha, wr_sha, last_sha  in  1/ADDRW/DATAW/1/1  same meanings for SHA
- bus_ready  in  1  downstream accepts the beat this cycle
- bus_valid  out  1  beat presented downstream
- bus_addr  out  ADDRW  muxed beat address
- bus_data  out  DATAW  muxed write data
- bus_wr  out  1  muxed write flag
- grant_aes  out  1  AES owns the bus (registered)
- grant_sha  out  1  SHA owns the bus (registered)
- ready_aes  out  1  AES beat accepted this cycle
- ready_sha  out  1  SHA beat accepted this cycle
- timeout_err  out  1  one-cycle pulse on watchdog release

Behaviour:
- State machine:
  - States IDLE, OWN_AES, OWN_SHA; grant_aes = (state==OWN_AES), grant_sha = (state==OWN_SHA).
  - Register prio: 0 = AES preferred, 1 = SHA preferred.
- Reset (async):
  - state = IDLE, prio = 0, watchdog counter = 0, timeout_err = 0.
  - All outputs are 0 during reset and the cycle after it.
  - Reset mid-transaction drops both grants immediately; no beat completes.
- IDLE:
  - Only one req high -> grant that requester next edge (1-cycle grant latency).
  - Both high -> grant the side selected by prio.
  - Neither high -> stay in IDLE.
- Muxing:
  - Granted: bus_valid = req_x; bus_addr/bus_data/bus_wr = granted requester's fields.
  - Not granted: bus_valid = 0; bus_addr/bus_data/bus_wr driven 0.
  - ready_x = grant_x & req_x & bus_ready, combinational.
  - Beat accepted when bus_valid & bus_ready.
- Release events while owning side x (evaluated each edge):
  - (a) Accepted beat with last_x = 1.
  - (b) req_x = 0 (abort).
  - (c) Watchdog reaches TIMEOUT.
  - On release: prio points to the other side. Next state = OWN_other if req_other, else IDLE. This gives direct handoff with no bubble.
  - A requester that released cannot be re-granted while the other side is requesting.
- Watchdog:
  - Counter clears on entry to any OWN state and on each accepted beat; otherwise increments every granted cycle.
  - When it reaches TIMEOUT: release, timeout_err = 1 for exactly one cycle (registered), counter cleared.
  - Counter width holds TIMEOUT without overflow.
- Priority between release events:
  - last-beat acceptance and the watchdog in the same cycle -> normal completion, no timeout_err.
  - Abort takes precedence over the watchdog.
- The block never reorders or buffers beats; it adds no latency on accepted beats.

Test Plan:
- After reset, req_aes=1 for a 3-beat write, bus_ready=1 -> grant_aes=1 one cycle after req; 3 accepted beats with bus_addr following addr_aes; grant_aes=0 the cycle after the last_aes beat; state IDLE.
- req_aes and req_sha asserted together after reset -> AES granted first. On the accepted last_aes beat, grant_sha=1 on the next edge with no idle cycle.
- SHA finishes while both request again -> AES granted next. Alternation holds for 4 consecutive transactions of each.
- TIMEOUT=8, AES granted, bus_ready=0 for 8 cycles -> timeout_err pulses once, grant_aes drops. SHA granted next if requesting; no beat reported accepted.
- AES granted, req_aes deasserted mid-transaction with no last -> grant released next edge, no timeout_err, prio moves to SHA.
- Assert rst_n=0 while grant_sha=1 and a beat is pending -> grant_sha, bus_valid and ready_sha go 0 immediately. After release, AES wins the first contended arbitration.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one downstream bus between the AES and SHA FSMs.
// A granted requester keeps the bus until its last beat is accepted, it drops
// its request, or the watchdog sees TIMEOUT granted cycles with no accepted beat.
//
//   state   | meaning
//   --------+-------------------------------------------
//   IDLE    | no owner, arbitrate on the next edge
//   OWN_AES | AES owns the bus, its beats are forwarded
//   OWN_SHA | SHA owns the bus, its beats are forwarded
module bus_arbiter #(
    parameter int ADDRW   = 24,
    parameter int DATAW   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_aes,
    input  logic [ADDRW-1:0] addr_aes,
    input  logic [DATAW-1:0] data_aes,
    input  logic             wr_aes,
    input  logic             last_aes,
    input  logic             req_sha,
    input  logic [ADDRW-1:0] addr_sha,
    input  logic [DATAW-1:0] data_sha,
    input  logic             wr_sha,
    input  logic             last_sha,
    input  logic             bus_ready,
    output logic             bus_valid,
    output logic [ADDRW-1:0] bus_addr,
    output logic [DATAW-1:0] bus_data,
    output logic             bus_wr,
    output logic             grant_aes,
    output logic             grant_sha,
    output logic             ready_aes,
    output logic             ready_sha,
    output logic             timeout_err
);

    localparam int CNTW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNTW-1:0] WDOG_LAST = CNTW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_AES = 2'd1,
        OWN_SHA = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_prio;        // 0: AES preferred, 1: SHA preferred
    logic            w_prio_nxt;
    logic [CNTW-1:0] r_wdog;
    logic            r_timeout_err;

    logic w_granted;
    logic w_req_own;
    logic w_last_own;
    logic w_accept;
    logic w_rel_last;
    logic w_abort;
    logic w_wdog;
    logic w_release;

    // Beat mux and release-event decode for the current owner
    always_comb begin
        grant_aes  = (r_state == OWN_AES);
        grant_sha  = (r_state == OWN_SHA);
        w_granted  = grant_aes | grant_sha;
        w_req_own  = 1'b0;
        w_last_own = 1'b0;
        bus_addr   = '0;
        bus_data   = '0;
        bus_wr     = 1'b0;
        if (grant_aes) begin
            w_req_own  = req_aes;
            w_last_own = last_aes;
            bus_addr   = addr_aes;
            bus_data   = data_aes;
            bus_wr     = wr_aes;
        end else if (grant_sha) begin
            w_req_own  = req_sha;
            w_last_own = last_sha;
            bus_addr   = addr_sha;
            bus_data   = data_sha;
            bus_wr     = wr_sha;
        end
        bus_valid  = w_req_own;
        ready_aes  = grant_aes & req_aes & bus_ready;
        ready_sha  = grant_sha & req_sha & bus_ready;
        w_accept   = bus_valid & bus_ready;
        w_rel_last = w_accept & w_last_own;
        w_abort    = w_granted & ~w_req_own;
        // An accepted beat resets the watchdog, so a last beat landing on the
        // final watchdog cycle completes normally; abort masks it via w_req_own.
        w_wdog     = w_granted & w_req_own & ~w_accept & (r_wdog == WDOG_LAST);
        w_release  = w_rel_last | w_abort | w_wdog;
    end

    // Next-state and round-robin pointer update
    always_comb begin
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio;
        case (r_state)
            IDLE: begin
                if (req_aes && (!req_sha || !r_prio)) begin
                    w_state_nxt = OWN_AES;
                end else if (req_sha) begin
                    w_state_nxt = OWN_SHA;
                end
            end
            OWN_AES: begin
                if (w_release) begin
                    w_prio_nxt  = 1'b1;
                    w_state_nxt = req_sha ? OWN_SHA : IDLE;
                end
            end
            OWN_SHA: begin
                if (w_release) begin
                    w_prio_nxt  = 1'b0;
                    w_state_nxt = req_aes ? OWN_AES : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, priority and timeout pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_prio        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_prio        <= w_prio_nxt;
            r_timeout_err <= w_wdog;
        end
    end

    // Watchdog: zero while idle (so every ownership starts at 0), on release
    // and on each accepted beat; otherwise count granted cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= '0;
        end else if (!w_granted || w_release || w_accept) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    assign timeout_err = r_timeout_err;

endmodule
